// File: rtl/rnn_pkg.sv
// ============================================================================
// rnn_pkg : shared Q8.8 constants, types and saturation helper for matvec_engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package rnn_pkg;

    localparam int ROWS      = 4;
    localparam int COLS      = 16;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 2 * DATA_W + $clog2(COLS);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);

    typedef logic signed [DATA_W-1:0]   q88_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        FLUSH = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } mv_state_t;

    localparam q88_t Q_MAX    = 16'sh7FFF;
    localparam q88_t Q_MIN    = 16'sh8000;
    localparam acc_t ACC_QMAX = acc_t'(Q_MAX);
    localparam acc_t ACC_QMIN = acc_t'(Q_MIN);

    // Rescale the Q16.16 accumulator back to Q8.8 and clamp to the word range.
    function automatic q88_t sat_q88(input acc_t a);
        acc_t s;
        s = a >>> FRAC_BITS;
        if (s > ACC_QMAX) begin
            return Q_MAX;
        end else if (s < ACC_QMIN) begin
            return Q_MIN;
        end else begin
            return q88_t'(s[DATA_W-1:0]);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// ============================================================================
// mac_unit : registered multiply, accumulate-with-clear, shift/saturate output.
// Optional fused ReLU on the output when MATVEC_RELU_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_unit
    import rnn_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  q88_t w_i,
    input  q88_t x_i,
    input  logic mul_en_i,
    input  logic first_i,
    output q88_t y_o
);

    prod_t prod_q;
    prod_t prod_d;
    logic  v1_q;
    logic  first_q;
    acc_t  acc_q;
    acc_t  acc_d;
    q88_t  y_sat;

    always_comb begin
        prod_d = prod_t'(w_i) * prod_t'(x_i);
        acc_d  = acc_q;
        // The first product of a row reloads the accumulator instead of adding.
        if (v1_q) begin
            acc_d = first_q ? acc_t'(prod_q) : acc_q + acc_t'(prod_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q  <= '0;
            v1_q    <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            v1_q    <= mul_en_i;
            first_q <= first_i;
            if (mul_en_i) begin
                prod_q <= prod_d;
            end
            acc_q   <= acc_d;
        end
    end

    assign y_sat = sat_q88(acc_q);

`ifdef MATVEC_RELU_EN
    assign y_o = y_sat[DATA_W-1] ? q88_t'(0) : y_sat;
`else
    assign y_o = y_sat;
`endif

endmodule

`default_nettype wire

// File: rtl/matvec_engine.sv
// ============================================================================
// matvec_engine : walks the weight/vector loaders and streams y = W*x per row.
// Build option: MATVEC_RELU_EN (fused ReLU on each result).
// Revision: 1.0
// ============================================================================
`default_nettype none

module matvec_engine
    import rnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] x_in,
    output logic [ROW_W-1:0]  sel_r,
    output logic [COL_W-1:0]  sel_c,
    output logic [COL_W-1:0]  sel_v,
    output logic              busy,
    output logic              y_valid,
    output logic [ROW_W-1:0]  y_idx,
    output logic [DATA_W-1:0] y_out,
    output logic              done
);

    mv_state_t        state_q;
    mv_state_t        state_d;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;
    logic             flush_q;
    logic             flush_d;
    q88_t             mac_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        flush_d = flush_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ISSUE: begin
                // The last column stays on the selects while the pipeline drains.
                if (col_q == COL_W'(COLS - 1)) begin
                    state_d = FLUSH;
                    flush_d = 1'b0;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            FLUSH: begin
                if (flush_q) begin
                    state_d = EMIT;
                end else begin
                    flush_d = 1'b1;
                end
            end
            EMIT: begin
                col_d = '0;
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = DONE;
                    row_d   = '0;
                end else begin
                    state_d = ISSUE;
                    row_d   = row_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
                flush_d = 1'b0;
            end
        endcase
    end

    mac_unit u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .w_i      (q88_t'(w_in)),
        .x_i      (q88_t'(x_in)),
        .mul_en_i (state_q == ISSUE),
        .first_i  (col_q == '0),
        .y_o      (mac_y)
    );

    assign sel_r   = row_q;
    assign sel_c   = col_q;
    assign sel_v   = col_q;
    assign busy    = (state_q == ISSUE) || (state_q == FLUSH) || (state_q == EMIT);
    assign y_valid = (state_q == EMIT);
    assign y_idx   = y_valid ? row_q : '0;
    assign y_out   = y_valid ? DATA_W'(mac_y) : '0;
    assign done    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_matvec_engine.sv
// ============================================================================
// tb_matvec_engine : directed scenarios with a scoreboard monitor for matvec_engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matvec_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] w_in;
    logic [15:0] x_in;
    logic [1:0]  sel_r;
    logic [3:0]  sel_c;
    logic [3:0]  sel_v;
    logic        busy;
    logic        y_valid;
    logic [1:0]  y_idx;
    logic [15:0] y_out;
    logic        done;

    logic [15:0] W [4][16];
    logic [15:0] X [16];

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   t0         = 0;
    int   yv_cnt     = 0;
    int   done_cnt   = 0;
    bit   done_armed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign w_in = W[sel_r][sel_c];
    assign x_in = X[sel_v];

    matvec_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .w_in    (w_in),
        .x_in    (x_in),
        .sel_r   (sel_r),
        .sel_c   (sel_c),
        .sel_v   (sel_v),
        .busy    (busy),
        .y_valid (y_valid),
        .y_idx   (y_idx),
        .y_out   (y_out),
        .done    (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, {1'b0, sel_r, sel_c, sel_v, busy, y_valid, y_idx, y_out, done}, 32'd0);
    endtask

    // Monitor: relative cycle n is the clock period that ends with edge n after start.
    initial begin : monitor
        exp_t e;
        int   rel;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                rel = cyc - t0 + 1;
                if (sel_v !== sel_c) begin
                    chk("sel_v_eq_sel_c", {28'd0, sel_v}, {28'd0, sel_c});
                end
                if (y_valid === 1'b1) begin
                    yv_cnt++;
                    if (q.size() == 0) begin
                        chk("unexpected_y_valid", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("y_idx", {30'd0, y_idx}, {30'd0, e.idx});
                        chk("y_out", {16'd0, y_out}, {16'd0, e.val});
                        chk("y_cycle", rel, e.cyc);
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    chk("done_expected", {31'd0, done_armed}, 32'd1);
                    chk("done_cycle", rel, 32'd77);
                    done_armed = 1'b0;
                end
            end
        end
    end

    task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++)
                W[r][c] = wv;
        for (int c = 0; c < 16; c++)
            X[c] = xv;
    endtask

    task automatic push_row(input int r, input logic [15:0] v);
        exp_t e;
        e.idx = r[1:0];
        e.val = v;
        e.cyc = (r + 1) * 19;
        q.push_back(e);
    endtask

    task automatic push_all(input logic [15:0] v);
        for (int r = 0; r < 4; r++)
            push_row(r, v);
    endtask

    // Returns at the negedge inside relative cycle 1 (first ISSUE cycle).
    task automatic start_pass();
        @(negedge clk);
        t0         = cyc + 1;
        start      = 1'b1;
        done_armed = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input string name);
        int yv0;
        int d0;
        int n;
        yv0 = yv_cnt;
        d0  = done_cnt;
        start_pass();
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) chk({name, "_timeout"}, 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        chk({name, "_y_count"}, yv_cnt - yv0, 32'd4);
        chk({name, "_queue_empty"}, q.size(), 32'd0);
        chk({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int yv0;
        int d0;
        reset_n = 1'b0;
        start   = 1'b0;
        fill(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset_outputs");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("post_reset_outputs");

        // 1: all ones -> 16.0 per row
        fill(16'h0100, 16'h0100);
        push_all(16'h1000);
        run_pass("s1");

        // 2: diagonal weight selects x[r] = r
        fill(16'h0000, 16'h0000);
        for (int r = 0; r < 4; r++) W[r][r] = 16'h0100;
        for (int c = 0; c < 16; c++) X[c] = {c[7:0], 8'h00};
        push_row(0, 16'h0000);
        push_row(1, 16'h0100);
        push_row(2, 16'h0200);
        push_row(3, 16'h0300);
        run_pass("s2");

        // 3: positive and negative saturation
        fill(16'h7FFF, 16'h7FFF);
        push_all(16'h7FFF);
        run_pass("s3_pos");
        fill(16'h8000, 16'h7FFF);
`ifdef MATVEC_RELU_EN
        push_all(16'h0000);
`else
        push_all(16'h8000);
`endif
        run_pass("s3_neg");

        // 4: -1.0 weights -> -16.0
        fill(16'hFF00, 16'h0100);
`ifdef MATVEC_RELU_EN
        push_all(16'h0000);
`else
        push_all(16'hF000);
`endif
        run_pass("s4");

        // 5: start pulses while busy are ignored
        fill(16'h0100, 16'h0100);
        push_all(16'h1000);
        yv0 = yv_cnt;
        d0  = done_cnt;
        start_pass();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (34) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        chk("s5_y_count", yv_cnt - yv0, 32'd4);
        chk("s5_done_count", done_cnt - d0, 32'd1);
        chk("s5_queue_empty", q.size(), 32'd0);
        chk("s5_idle", {31'd0, busy}, 32'd0);

        // 6: reset during row 2 ISSUE aborts the pass
        push_row(0, 16'h1000);
        push_row(1, 16'h1000);
        yv0 = yv_cnt;
        d0  = done_cnt;
        start_pass();
        repeat (44) @(negedge clk);
        chk("s6_row2_busy", {30'd0, sel_r}, 32'd2);
        reset_n    = 1'b0;
        done_armed = 1'b0;
        #1;
        chk_idle_outputs("s6_abort_outputs");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("s6_y_count", yv_cnt - yv0, 32'd2);
        chk("s6_done_count", done_cnt - d0, 32'd0);
        chk("s6_queue_empty", q.size(), 32'd0);
        chk_idle_outputs("s6_idle_outputs");

        push_all(16'h1000);
        run_pass("s6_rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
